// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with an in-order fetch queue.
// Requests are issued only when the queue and the in-flight requests together
// stay below QUEUE_DEPTH. This guarantees that every response has a free slot.
// A redirect flushes the queue and marks the in-flight responses for discard.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds the instr_misalign output.
// That output is a per-entry flag, set when PC[1:0] != 0.
module fetch_queue_stage #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h00000000,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            pc_branch_en_sel,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            instr_misalign,
`endif
  output logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fpc_r;
  logic [XLEN-1:0]  rsp_pc_r;
  logic [XLEN-1:0]  q_pc_r   [QUEUE_DEPTH];
  logic [XLEN-1:0]  q_data_r [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] outst_r;
  logic [CNT_W-1:0] drop_r;
  logic             valid_r;

  logic [SUM_W-1:0] inflight_s;
  logic             req_valid_s;
  logic             xfer_s;
  logic             drop_rsp_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] outst_next_s;
  logic [CNT_W-1:0] count_next_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic q_mis_r [QUEUE_DEPTH];

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction
`endif

  // Credit check, handshake decode and next-state counters.
  always_comb begin
    inflight_s  = {1'b0, count_r} + {1'b0, outst_r};
    req_valid_s = 1'b0;
    if (reset_n && !pc_branch_en_sel && (inflight_s < SUM_W'(QUEUE_DEPTH))) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    xfer_s       = req_valid_s && imem_req_ready;
    drop_rsp_s   = imem_rsp_valid && (drop_r != CNT_W'(0));
    // A response arriving with a redirect belongs to the old stream, so it is not queued.
    push_s       = imem_rsp_valid && !drop_rsp_s && !pc_branch_en_sel;
    pop_s        = valid_r && instr_ready && !pc_branch_en_sel;
    outst_next_s = outst_r + CNT_W'(xfer_s) - CNT_W'(imem_rsp_valid);
    count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Control state: fetch PC, response PC tag, pointers, counters and redirect flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_r    <= RESET_PC;
      rsp_pc_r <= RESET_PC;
      head_r   <= PTR_W'(0);
      tail_r   <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      outst_r  <= CNT_W'(0);
      drop_r   <= CNT_W'(0);
      valid_r  <= 1'b0;
    end else if (pc_branch_en_sel) begin
      // Every request still in flight now belongs to the stale stream.
      fpc_r    <= pc_branch;
      rsp_pc_r <= pc_branch;
      head_r   <= PTR_W'(0);
      tail_r   <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      outst_r  <= outst_next_s;
      drop_r   <= outst_next_s;
      valid_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        fpc_r <= fpc_r + XLEN'(4);
      end
      // Responses return in order after a redirect, so the next kept response is at rsp_pc_r.
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + XLEN'(4);
        tail_r   <= tail_r + PTR_W'(1);
      end
      if (drop_rsp_s) begin
        drop_r <= drop_r - CNT_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      outst_r <= outst_next_s;
      valid_r <= (count_next_s != CNT_W'(0));
    end
  end

  // Queue storage: the tail captures each kept response together with its request PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_r[i]   <= XLEN'(0);
        q_data_r[i] <= XLEN'(0);
`ifdef FETCH_MISALIGN_CHECK_EN
        q_mis_r[i]  <= 1'b0;
`endif
      end
    end else if (push_s) begin
      q_pc_r[tail_r]   <= rsp_pc_r;
      q_data_r[tail_r] <= imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
      q_mis_r[tail_r]  <= pc_misaligned(rsp_pc_r);
`endif
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fpc_r;
  assign instr_valid    = valid_r;
  assign instr_f        = q_data_r[head_r];
  assign pc_f           = q_pc_r[head_r];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign instr_misalign = q_mis_r[head_r];
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage.
// Instance u_dut uses RESET_PC 0. Instance u_wrap starts at 0xFFFFFFFC.
// Each instance has a small in-order memory model.
// Every memory word is the address XOR 0xC0DE0000.
module tb_fetch_queue_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_branch;
  logic        br_en;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_f;
  logic [31:0] pc_f;

  logic [31:0] b_pc_branch;
  logic        b_br_en;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_instr_valid;
  logic        b_instr_ready;
  logic [31:0] b_instr_f;
  logic [31:0] b_pc_f;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign;
  logic        b_misalign;
`endif

  logic [31:0] pend_a [$];
  logic [31:0] pend_b [$];
  logic        mem_hold;
  int          xfer_cnt;
  int          n_vec;
  int          n_err;

  fetch_queue_stage #(.XLEN(32), .RESET_PC(32'h00000000), .QUEUE_DEPTH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .pc_branch(pc_branch), .pc_branch_en_sel(br_en),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
`ifdef FETCH_MISALIGN_CHECK_EN
    .instr_misalign(misalign),
`endif
    .instr_f(instr_f), .pc_f(pc_f)
  );

  fetch_queue_stage #(.XLEN(32), .RESET_PC(32'hFFFFFFFC), .QUEUE_DEPTH(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .pc_branch(b_pc_branch), .pc_branch_en_sel(b_br_en),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
`ifdef FETCH_MISALIGN_CHECK_EN
    .instr_misalign(b_misalign),
`endif
    .instr_f(b_instr_f), .pc_f(b_pc_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then drive the next responses after it.
  task automatic tick();
    logic        xa;
    logic        xb;
    logic        ra;
    logic        rb;
    logic [31:0] aa;
    logic [31:0] ab;
    logic [31:0] junk;
    @(negedge clk);
    xa = req_valid && req_ready;
    aa = req_addr;
    ra = rsp_valid;
    xb = b_req_valid && b_req_ready;
    ab = b_req_addr;
    rb = b_rsp_valid;
    @(posedge clk);
    #1;
    if (ra && pend_a.size() > 0) junk = pend_a.pop_front();
    if (xa) begin
      pend_a.push_back(aa);
      xfer_cnt++;
    end
    if (rb && pend_b.size() > 0) junk = pend_b.pop_front();
    if (xb) pend_b.push_back(ab);
    if (!mem_hold && pend_a.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend_a[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
    if (pend_b.size() > 0) begin
      b_rsp_valid = 1'b1;
      b_rsp_data  = mem_word(pend_b[0]);
    end else begin
      b_rsp_valid = 1'b0;
      b_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    br_en       = 1'b0;
    pc_branch   = 32'h0;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    b_rsp_valid = 1'b0;
    b_rsp_data  = 32'h0;
    mem_hold    = 1'b0;
    pend_a.delete();
    pend_b.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_valid", {31'h0, req_valid}, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc_f", pc_f, 32'h0);
    check("rst_instr_f", instr_f, 32'h0);
    check("rst_wrap_pc_f", b_pc_f, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", {31'h0, misalign}, 32'h0);
`endif
    reset_n = 1'b1;
    #1;
    xfer_cnt = 0;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    xfer_cnt      = 0;
    reset_n       = 1'b0;
    req_ready     = 1'b1;
    instr_ready   = 1'b1;
    b_pc_branch   = 32'h0;
    b_br_en       = 1'b0;
    b_req_ready   = 1'b1;
    b_instr_ready = 1'b0;

    // Reset and sequential fetch with 1-cycle memory latency.
    do_reset();
    check("first_req_valid", {31'h0, req_valid}, 32'h1);
    check("first_req_addr", req_addr, 32'h0);
    check("wrap_first_addr", b_req_addr, 32'hFFFFFFFC);
    tick();
    check("seq_valid_c2", {31'h0, instr_valid}, 32'h0);
    tick();
    check("seq_valid_c3", {31'h0, instr_valid}, 32'h1);
    check("seq_pc0", pc_f, 32'h0);
    check("seq_instr0", instr_f, mem_word(32'h0));
    tick();
    check("seq_pc4", pc_f, 32'h4);
    check("seq_instr4", instr_f, mem_word(32'h4));
    tick();
    check("seq_pc8", pc_f, 32'h8);
    tick();
    check("seq_pcC", pc_f, 32'hC);
    check("seq_instrC", instr_f, mem_word(32'hC));
    check("seq_fetch_addr", req_addr, 32'h14);

    // Backpressure: decode stalls for 10 cycles. The wrap instance is also stalled.
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) check("bp_head_stable", pc_f, 32'h0);
    end
    check("bp_req_count", xfer_cnt, 32'd4);
    check("bp_req_valid", {31'h0, req_valid}, 32'h0);
    check("bp_instr_valid", {31'h0, instr_valid}, 32'h1);
    check("bp_instr0", instr_f, mem_word(32'h0));
    check("wrap_head_pc", b_pc_f, 32'hFFFFFFFC);
    check("wrap_head_instr", b_instr_f, mem_word(32'hFFFFFFFC));
    b_instr_ready = 1'b1;
    instr_ready   = 1'b1;
    tick();
    check("bp_drain_pc4", pc_f, 32'h4);
    check("wrap_pc_zero", b_pc_f, 32'h0);
    check("wrap_instr_zero", b_instr_f, mem_word(32'h0));
    tick();
    check("wrap_pc_four", b_pc_f, 32'h4);
    b_instr_ready = 1'b0;

    // Redirect while the queue holds entries and two responses are still outstanding.
    do_reset();
    instr_ready = 1'b0;
    tick();
    tick();
    mem_hold = 1'b1;
    tick();
    tick();
    check("rd_head_before", pc_f, 32'h0);
    br_en       = 1'b1;
    pc_branch   = 32'h100;
    mem_hold    = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("rd_req_suppressed", {31'h0, req_valid}, 32'h0);
    tick();
    br_en = 1'b0;
    check("rd_flushed", {31'h0, instr_valid}, 32'h0);
    tick();
    check("rd_drop1", {31'h0, instr_valid}, 32'h0);
    tick();
    check("rd_drop2", {31'h0, instr_valid}, 32'h0);
    tick();
    check("rd_valid", {31'h0, instr_valid}, 32'h1);
    check("rd_pc100", pc_f, 32'h100);
    check("rd_instr100", instr_f, mem_word(32'h100));
    tick();
    check("rd_pc104", pc_f, 32'h104);

    // Back-to-back redirects to 0x200 and then 0x300 while responses are still being dropped.
    do_reset();
    instr_ready = 1'b1;
    mem_hold    = 1'b1;
    tick();
    tick();
    br_en     = 1'b1;
    pc_branch = 32'h200;
    mem_hold  = 1'b0;
    tick();
    br_en = 1'b0;
    tick();
    check("bb_valid_a", {31'h0, instr_valid}, 32'h0);
    br_en     = 1'b1;
    pc_branch = 32'h300;
    tick();
    br_en = 1'b0;
    check("bb_valid_b", {31'h0, instr_valid}, 32'h0);
    tick();
    check("bb_valid_c", {31'h0, instr_valid}, 32'h0);
    tick();
    check("bb_pc300", pc_f, 32'h300);
    check("bb_instr300", instr_f, mem_word(32'h300));
    tick();
    check("bb_pc304", pc_f, 32'h304);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect target.
    do_reset();
    instr_ready = 1'b1;
    br_en       = 1'b1;
    pc_branch   = 32'h102;
    tick();
    br_en = 1'b0;
    tick();
    tick();
    check("mis_pc", pc_f, 32'h102);
    check("mis_flag", {31'h0, misalign}, 32'h1);
    check("mis_instr", instr_f, mem_word(32'h102));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded at reset.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, meaning the fetch queue entries; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pc_branch, input, XLEN bits: redirect target.
REQ-007 SHALL have port pc_branch_en_sel, input, 1 bit: redirect strobe.
REQ-008 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-009 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 SHALL have port imem_req_addr, output, XLEN bits: fetch address.
REQ-011 SHALL have port imem_rsp_valid, input, 1 bit: response valid; responses return in order, at least 1 cycle after acceptance.
REQ-012 SHALL have port imem_rsp_data, input, XLEN bits: instruction word.
REQ-013 SHALL have port instr_valid, output, 1 bit: queue head valid.
REQ-014 SHALL have port instr_ready, input, 1 bit: decode consumes the head.
REQ-015 SHALL have port instr_f, output, XLEN bits: head instruction.
REQ-016 SHALL have port pc_f, output, XLEN bits: head PC.

Function
REQ-017 SHALL hold fetch PC fpc; a request transfers when imem_req_valid && imem_req_ready, then fpc <= fpc + 4, with wrap-around modulo 2^XLEN.
REQ-018 SHALL assert imem_req_valid only when (queue count + outstanding) < QUEUE_DEPTH and pc_branch_en_sel is low; imem_req_addr = fpc.
REQ-019 SHALL count outstanding requests (0..QUEUE_DEPTH): +1 on transfer, -1 on imem_rsp_valid; both in one cycle leaves the count unchanged.
REQ-020 SHALL write each non-dropped response, with its request PC, into the queue tail at the clock edge; instr_valid rises the following cycle, with no bypass.
REQ-021 SHALL pop the head when instr_valid && instr_ready; push and pop in the same cycle leaves the count unchanged.
REQ-022 SHALL never overflow, because the credit rule in REQ-018 guarantees space; the queue is full at QUEUE_DEPTH and empty at 0, and pointers wrap modulo QUEUE_DEPTH.
REQ-023 SHALL act on pc_branch_en_sel in the same cycle: clear the queue, set fpc <= pc_branch, suppress the request, ignore any pop, and set drop_cnt <= outstanding after this cycle's response accounting.
REQ-024 SHALL discard responses while drop_cnt > 0, decrementing drop_cnt and outstanding; the first post-redirect instruction is pc_branch.
REQ-025 SHALL let a redirect arriving while drop_cnt > 0 reload drop_cnt per REQ-023.
REQ-026 SHALL hold instr_f and pc_f stable while instr_valid && !instr_ready.

Reset
REQ-027 SHALL on reset_n low asynchronously set fpc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, instr_valid = 0, imem_req_valid = 0, instr_f = 0, pc_f = 0.
REQ-028 SHALL permit the first request in the first cycle after reset_n deasserts; responses to requests issued before a mid-operation reset are the memory's responsibility and are not tracked.

Configuration
REQ-029 SHALL, with macro FETCH_MISALIGN_CHECK_EN defined, add output instr_misalign (1 bit) per queue entry, set when the entry PC[1:0] != 0; it is reset to 0 and the entry is still delivered.
REQ-030 SHALL, without FETCH_MISALIGN_CHECK_EN, omit port instr_misalign and its storage, and ignore PC[1:0].

Verification
REQ-031 SHALL verify reset then sequential fetch: RESET_PC=0, memory ready always with 1-cycle latency, instr_ready=1 -> pc_f sequence 0,4,8,C; first instr_valid appears 3 cycles after reset release.
REQ-032 SHALL verify backpressure: instr_ready=0 for 10 cycles -> exactly 4 requests issued, queue full, imem_req_valid=0, head pc_f=0 stable.
REQ-033 SHALL verify redirect with in-flight responses: 2 outstanding, pc_branch=0x100 -> both responses dropped, queue empty, next delivered pc_f=0x100, then 0x104.
REQ-034 SHALL verify PC wrap: RESET_PC=0xFFFFFFFC -> pc_f 0xFFFFFFFC then 0x00000000.
REQ-035 SHALL verify back-to-back redirects to 0x200 then 0x300 during drop -> only 0x300 stream is delivered.
REQ-036 SHALL verify that, with FETCH_MISALIGN_CHECK_EN, a redirect to 0x102 -> instr_misalign=1 with pc_f=0x102.
